// File: rtl/prbs_4ask_upsampler.sv
// PRBS-driven 4-ASK symbol source with sys_clk/4 sample and sys_clk/16 symbol strobes.
// Zero-stuff or sample-and-hold 4x upsampling onto x_out for the time-shared filter.
module prbs_4ask_upsampler #(
  parameter int unsigned               WIDTH = 18,
  parameter logic [14:0]               SEED  = 15'h0001,
  parameter logic signed [WIDTH-1:0]   LVL_A = 18'sd32768,
  parameter bit                        HOLD  = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    run,
  output logic                    sam_clk_en,
  output logic                    sym_clk_en,
  output logic signed [WIDTH-1:0] x_out,
  output logic [1:0]              sym_out
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LFSR_W = 15;
  localparam int unsigned WIDE_W = WIDTH + 2;

  // Levels are formed two bits wider so 3*LVL_A is exact before narrowing.
  localparam logic signed [WIDE_W-1:0] LVL_A_W  = WIDE_W'(LVL_A);
  localparam logic signed [WIDE_W-1:0] LVL_3A_W = LVL_A_W + LVL_A_W + LVL_A_W;

  logic [CNT_W-1:0]        cnt_q,  cnt_d;
  logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
  logic signed [WIDTH-1:0] x_q,    x_d;
  logic [1:0]              sym_q,  sym_d;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  function automatic logic signed [WIDTH-1:0] gray_map(input logic [1:0] s);
    logic signed [WIDE_W-1:0] lvl;
    case (s)
      2'b00:   lvl = -LVL_3A_W;
      2'b01:   lvl = -LVL_A_W;
      2'b11:   lvl = LVL_A_W;
      default: lvl = LVL_3A_W;
    endcase
    return WIDTH'(lvl);
  endfunction

  // Strobes decode straight from the registered counter so they align with cnt.
  assign sam_clk_en = run & (cnt_q[1:0] == 2'b11);
  assign sym_clk_en = run & (cnt_q == 4'hF);

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    x_d    = x_q;
    sym_d  = sym_q;
    if (run) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (sym_clk_en) begin
      lfsr_d = lfsr_step(lfsr_step(lfsr_q));
      sym_d  = lfsr_d[1:0];
      x_d    = gray_map(lfsr_d[1:0]);
    end else if (sam_clk_en && !HOLD) begin
      x_d = '0;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      lfsr_q <= SEED;
      x_q    <= '0;
      sym_q  <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      x_q    <= x_d;
      sym_q  <= sym_d;
    end
  end

  assign x_out   = x_q;
  assign sym_out = sym_q;

endmodule

// File: tb/tb_prbs_4ask_upsampler.sv
// Scoreboard bench for prbs_4ask_upsampler: zero-stuff and hold instances run side by side
// against a symbol-level reference model, with random run gaps and a mid-symbol async reset.
module tb_prbs_4ask_upsampler;

  localparam int WIDTH = 18;
  localparam int LVL_A = 32768;
  localparam logic signed [WIDTH-1:0] LVL_A_P = 18'(LVL_A);
  localparam logic [14:0] SEED = 15'h0001;

  logic clk = 1'b0;
  logic reset;
  logic run;
  logic sam0, sym0, sam1, sym1;
  logic signed [WIDTH-1:0] x0, x1;
  logic [1:0] so0, so1;

  prbs_4ask_upsampler #(.WIDTH(WIDTH), .SEED(SEED), .LVL_A(LVL_A_P), .HOLD(1'b0)) u_zs (
    .sys_clk(clk), .reset(reset), .run(run), .sam_clk_en(sam0), .sym_clk_en(sym0),
    .x_out(x0), .sym_out(so0));

  prbs_4ask_upsampler #(.WIDTH(WIDTH), .SEED(SEED), .LVL_A(LVL_A_P), .HOLD(1'b1)) u_hd (
    .sys_clk(clk), .reset(reset), .run(run), .sam_clk_en(sam1), .sym_clk_en(sym1),
    .x_out(x1), .sym_out(so1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int q_x0[$];
  int q_x1[$];
  int q_sy[$];
  logic [14:0] m_lfsr;
  int a = 0;
  bit stats_en = 1'b0;
  int lv_cnt[4];

  initial assert (3 * LVL_A <= (1 << (WIDTH - 1)) - 1)
    else $fatal(1, "FAIL param_range: 3*LVL_A=%0d exceeds %0d", 3 * LVL_A, (1 << (WIDTH - 1)) - 1);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic int level_of(logic [1:0] s);
    case (s)
      2'b00:   return -3 * LVL_A;
      2'b01:   return -LVL_A;
      2'b11:   return LVL_A;
      default: return 3 * LVL_A;
    endcase
  endfunction

  // Consumer view after reset: one all-zero symbol window, then one window per symbol.
  function automatic void model_reset();
    q_x0.delete(); q_x1.delete(); q_sy.delete();
    m_lfsr = SEED;
    for (int i = 0; i < 4; i++) begin
      q_x0.push_back(0); q_x1.push_back(0); q_sy.push_back(0);
    end
  endfunction

  function automatic void push_syms(int n);
    int lv;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 2; j++) m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
      lv = level_of(m_lfsr[1:0]);
      for (int i = 0; i < 4; i++) begin
        q_x0.push_back(i == 0 ? lv : 0);
        q_x1.push_back(lv);
        q_sy.push_back(int'(m_lfsr[1:0]));
      end
    end
  endfunction

  // Monitor: strobe timing from the count of running cycles, samples from the scoreboard.
  logic signed [WIDTH-1:0] px0, px1;
  logic [1:0] pso0, pso1;
  logic psam, psym;
  bit esam, esym;
  int ex0, ex1, esy;

  always @(negedge clk) begin
    if (reset) begin
      chk("strobe_in_reset", longint'(sam0 | sym0 | sam1 | sym1), 0);
      a = 0; px0 = '0; px1 = '0; pso0 = '0; pso1 = '0; psam = 1'b0; psym = 1'b0;
    end else begin
      esam = run && (a % 4 == 3);
      esym = run && (a % 16 == 15);
      chk("sam_zs", longint'(sam0), longint'(esam));
      chk("sam_hd", longint'(sam1), longint'(esam));
      chk("sym_zs", longint'(sym0), longint'(esym));
      chk("sym_hd", longint'(sym1), longint'(esym));
      chk("x_zs_change_off_sam", longint'((x0 != px0) && !psam), 0);
      chk("x_hd_change_off_sym", longint'((x1 != px1) && !psym), 0);
      chk("sym_out_change_off_sym", longint'(((so0 != pso0) || (so1 != pso1)) && !psym), 0);
      if (sam0) begin
        if (q_x0.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          ex0 = q_x0.pop_front(); ex1 = q_x1.pop_front(); esy = q_sy.pop_front();
          chk("x_zs_sample", longint'(x0), longint'(ex0));
          chk("x_hd_sample", longint'(x1), longint'(ex1));
          chk("sym_out_zs", longint'(so0), longint'(esy));
          chk("sym_out_hd", longint'(so1), longint'(esy));
        end
        if (stats_en) lv_cnt[so0]++;
      end
      if (run) a++;
      px0 = x0; px1 = x1; pso0 = so0; pso1 = so1; psam = sam0; psym = sym0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_first_symbol(string tag);
    repeat (16) @(posedge clk);
    #1;
    chk({tag, "_x_zs"}, longint'(x0), -98304);
    chk({tag, "_x_hd"}, longint'(x1), -98304);
    chk({tag, "_x_raw"}, longint'(x0[17:0]), longint'(18'h28000));
    chk({tag, "_sym_out"}, longint'(so0), 0);
    #1;
  endtask

  bit found;
  int total;

  initial begin
    reset = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 4; i++) lv_cnt[i] = 0;
    repeat (3) tick();
    model_reset();
    push_syms(40);
    reset = 1'b0;
    run = 1'b1;
    check_first_symbol("first_sym");
    repeat (64) tick();

    // Freeze at cnt=9 for seven cycles.
    repeat (9) tick();
    run = 1'b0;
    repeat (7) tick();
    run = 1'b1;

    repeat (300) begin
      tick();
      run = ($urandom_range(0, 3) != 0);
    end

    // Async reset pulsed between edges at cnt=6.
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      tick();
      if (a % 16 == 6) found = 1'b1;
    end
    chk("reach_cnt6", longint'(found), 1);
    reset = 1'b1;
    model_reset();
    push_syms(2100);
    #1;
    chk("async_rst_x_zs", longint'(x0), 0);
    chk("async_rst_x_hd", longint'(x1), 0);
    chk("async_rst_sym_out", longint'({so0, so1}), 0);
    chk("async_rst_strobes", longint'(sam0 | sam1 | sym0 | sym1), 0);
    #1;
    tick();
    tick();
    reset = 1'b0;
    check_first_symbol("restart_sym");
    repeat (64) tick();

    stats_en = 1'b1;
    repeat (2000 * 16) tick();
    stats_en = 1'b0;
    total = lv_cnt[0] + lv_cnt[1] + lv_cnt[2] + lv_cnt[3];
    chk("level_samples", longint'(total > 0), 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("level_share_%0d_in_20_30pct(count=%0d)", i, lv_cnt[i]),
          longint'((lv_cnt[i] * 5 >= total) && (lv_cnt[i] * 10 <= total * 3)), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs_4ask_upsampler.md
Name: prbs_4ask_upsampler

Overview:
Test-stimulus source that sits directly upstream of the 101-tap time-shared pulse-shaping filter. Divides sys_clk to produce the sample enable (sys_clk/4) and the symbol enable (sys_clk/16), generating the time base the filter's 4-phase time-sharing depends on. Draws 2-bit symbols from a 15-bit PRBS, Gray-maps them to 4-ASK levels in 1s17, and upsamples by 4 (zero-stuff or hold) onto x_out, which drives the filter's x_in.

Parameters:
WIDTH, 18, sample width (1s17 signed)
SEED, 15'h0001, LFSR reset value; must be nonzero
LVL_A, 18'sd32768, inner level a (0.25); outer level is 3*LVL_A (98304 = 0.75)
HOLD, 0, 0 = zero-stuff upsampling; 1 = sample-and-hold upsampling

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  1 = time base advances; 0 = freeze all state
sam_clk_en  out  1  one-cycle sample strobe, every 4 sys_clk
sym_clk_en  out  1  one-cycle symbol strobe, every 16 sys_clk
x_out  out  WIDTH  signed 1s17 upsampled symbol stream, drives filter x_in
sym_out  out  2  current symbol bits (debug / BER reference)

Behaviour:
- Reset (async, any time including mid-symbol): cnt=0, lfsr=SEED, x_out=0, sym_out=2'b00. Strobes low while reset is asserted.
- cnt: 4-bit register. Increments modulo 16 on each sys_clk edge while run=1. Holds while run=0.
- sam_clk_en = run & (cnt[1:0]==2'b11). Decoded from the registered cnt, with no added latency.
- sym_clk_en = run & (cnt==4'hF). Every sym_clk_en cycle is also a sam_clk_en cycle.
- LFSR step function: s' = {s[13:0], s[14]^s[13]} (x^15+x^14+1, period 32767).
- On an edge with sym_clk_en=1:
  - lfsr advances exactly 2 steps.
  - sym_out <= new lfsr[1:0].
  - x_out <= map(new lfsr[1:0]).
- Gray map: 00 -> -3*LVL_A; 01 -> -LVL_A; 11 -> +LVL_A; 10 -> +3*LVL_A.
- The map is computed at full precision and must not overflow WIDTH. Parameter values with 3*LVL_A > 2^(WIDTH-1)-1 are illegal; the bench checks this with an assertion.
- On an edge with sam_clk_en=1 and sym_clk_en=0:
  - HOLD=0: x_out <= 0.
  - HOLD=1: x_out holds.
  - lfsr and sym_out hold in both modes.
- Resulting timing (HOLD=0):
  - x_out carries the symbol level during cnt=0..3 and is 0 during cnt=4..15.
  - The consumer samples on sam_clk_en (cnt=3,7,11,15) and so sees the sequence level,0,0,0.
  - x_out is constant across every 4-cycle window ending in a sam_clk_en, which the downstream 4-phase time-sharing requires.
- Latency: a symbol is presented on x_out 1 sys_clk after its sym_clk_en. The filter captures it at the next sam_clk_en, 4 sys_clk later.
- run=0 mid-symbol: cnt, lfsr, x_out and sym_out all freeze and both strobes are low. On run=1, operation resumes from the frozen cnt with no lost or duplicated samples.
- run and reset together: reset dominates.
- All registers are updated only on sys_clk. There are no other clocks and no combinational paths from x_out to the strobes.

Test Plan:
1. Reset release with run=1, SEED=1, HOLD=0:
   - sam_clk_en is high on cycles 3,7,11,15 after release; sym_clk_en is high on cycle 15 only.
   - After the cycle-15 edge: lfsr=15'h0004, sym_out=2'b00, x_out=-98304 (18'h28000).
2. Zero-stuff check over 4 symbols:
   - x_out sampled at each sam_clk_en equals [L,0,0,0] per symbol.
   - L matches a software model of the LFSR plus Gray map.
   - x_out never changes except on sam_clk_en edges.
3. HOLD=1:
   - x_out sampled at each sam_clk_en equals [L,L,L,L] per symbol.
   - Transitions occur only on sym_clk_en edges.
4. run deasserted for 7 cycles at cnt=9:
   - Strobes stay low and cnt stays at 9; lfsr and x_out are unchanged.
   - After run=1, the next sam_clk_en occurs 2 cycles later (cnt=11).
5. Async reset pulsed mid-symbol (cnt=6, between clock edges):
   - x_out, sym_out and cnt become 0 and lfsr=SEED immediately, without waiting for a clock edge.
   - After release, the symbol sequence restarts identical to test 1.
6. Long run of 32767 symbols:
   - The sym_out sequence repeats with period 32767 (odd period, 2 steps per symbol).
   - All four levels appear, each about 25% of the time.
   - lfsr is never 0.
